// File: rtl/cmd_frame_decoder.sv
// -----------------------------------------------------------------------------
// cmd_frame_decoder
//
// Framed host-command decoder for the logic-analyser control path.
// A frame is: SYNC, order byte, ARG_BYTES argument bytes, and an optional
// XOR checksum byte (order ^ all arguments). A good frame updates Order/Data
// and fires one-cycle command pulses. Bad frames (checksum mismatch, SYNC
// inside a frame, inter-byte timeout, or an unknown opcode) pulse FrameErr.
//
// Ports:
//   CLK          system clock, rising edge
//   CLR          synchronous active-high reset
//   DataIn       received byte
//   DataValid    DataIn valid this cycle (one byte per high cycle)
//   Locked       PLL lock
//   Order        order byte of the last good frame
//   Data         arguments of the last good frame, first byte in the MSBs
//   CmdStrobe    pulse: good frame executed
//   ClrAll       pulse: order all-ones (also sets TrigEN)
//   adden        pulse: order 1110xxxx
//   SetInit      pulse for order 1101xxxx, ORed with !Locked
//   TrigEN       level: set by 1100xxxx, cleared by 1011xxxx
//   SetTrigTime  pulse: order 1010xxxx
//   SoftReload   pulse: order 1001xxxx
//   SerPLL       pulse: order 1000xxxx
//   FrameErr     pulse on any frame error
//   Busy         FSM not idle
// -----------------------------------------------------------------------------
module cmd_frame_decoder #(
  parameter int            DW        = 8,
  parameter int            ARG_BYTES = 2,
  parameter logic [DW-1:0] SYNC      = 8'hA5,
  parameter bit            CKSUM_EN  = 1'b1,
  parameter int            TIMEOUT   = 1023
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic [DW-1:0]           DataIn,
  input  logic                    DataValid,
  input  logic                    Locked,
  output logic [DW-1:0]           Order,
  output logic [ARG_BYTES*DW-1:0] Data,
  output logic                    CmdStrobe,
  output logic                    ClrAll,
  output logic                    adden,
  output logic                    SetInit,
  output logic                    TrigEN,
  output logic                    SetTrigTime,
  output logic                    SoftReload,
  output logic                    SerPLL,
  output logic                    FrameErr,
  output logic                    Busy
);

  localparam int AW = (ARG_BYTES > 1) ? $clog2(ARG_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [AW-1:0] LAST_ARG = AW'(ARG_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORDER,
    S_ARGS,
    S_CHK,
    S_EXEC
  } state_t;

  state_t r_state, w_state_nxt;

  // Shadow (in-flight) frame
  logic [DW-1:0]           r_sh_order;
  logic [ARG_BYTES*DW-1:0] r_sh_data, w_sh_data_nxt;
  logic [DW-1:0]           r_xor;
  logic [AW-1:0]           r_arg_idx;
  logic [TW-1:0]           r_tcnt;

  // Architectural outputs
  logic [DW-1:0]           r_order;
  logic [ARG_BYTES*DW-1:0] r_data;
  logic r_cmd, r_clrall, r_adden, r_setinit, r_trig, r_settrig, r_softrld, r_serpll, r_ferr;

  // Frame-level events
  logic w_sync, w_in_frame, w_timeout, w_last_arg, w_ck_ok;
  logic w_abort, w_ck_err, w_exec_go;

  // Opcode decode of the shadow order
  logic [3:0] w_op_hi;
  logic w_is_ff, w_op_valid;
  logic w_dec_clrall, w_dec_adden, w_dec_setinit, w_dec_trig_set, w_dec_trig_clr;
  logic w_dec_settrig, w_dec_softrld, w_dec_serpll;

  // Next values of the registered outputs
  logic w_cmd_nxt, w_ferr_nxt, w_trig_nxt;

  assign w_sync     = DataValid && (DataIn == SYNC);
  assign w_in_frame = (r_state == S_ORDER) || (r_state == S_ARGS) || (r_state == S_CHK);
  assign w_last_arg = (r_arg_idx == LAST_ARG);
  assign w_ck_ok    = (DataIn == r_xor);

  // A byte in the expiry cycle wins, hence the !DataValid term.
  assign w_timeout  = (TIMEOUT != 0) && w_in_frame && !DataValid && (r_tcnt == TO_LAST);

  assign w_abort    = w_in_frame && w_sync;
  assign w_ck_err   = (r_state == S_CHK) && DataValid && !w_sync && !w_ck_ok;
  assign w_exec_go  = ((r_state == S_ARGS) && DataValid && !w_sync && w_last_arg && !CKSUM_EN)
                   || ((r_state == S_CHK)  && DataValid && !w_sync && w_ck_ok);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch forms.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_sync) w_state_nxt = S_ORDER;
      end
      S_ORDER: begin
        if (DataValid)      w_state_nxt = w_sync ? S_ORDER : S_ARGS;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_ARGS: begin
        if (DataValid) begin
          if (w_sync)          w_state_nxt = S_ORDER;
          else if (w_last_arg) w_state_nxt = CKSUM_EN ? S_CHK : S_EXEC;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHK: begin
        if (DataValid) begin
          if (w_sync)       w_state_nxt = S_ORDER;
          else if (w_ck_ok) w_state_nxt = S_EXEC;
          else              w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values for the registered outputs)
  // ---------------------------------------------------------------------------
  assign w_op_hi = r_sh_order[DW-1 -: 4];
  assign w_is_ff = &r_sh_order;

  always_comb begin
    w_dec_clrall   = 1'b0;
    w_dec_adden    = 1'b0;
    w_dec_setinit  = 1'b0;
    w_dec_trig_set = 1'b0;
    w_dec_trig_clr = 1'b0;
    w_dec_settrig  = 1'b0;
    w_dec_softrld  = 1'b0;
    w_dec_serpll   = 1'b0;
    case (w_op_hi)
      4'hF:    w_dec_clrall   = w_is_ff;  // other 1111xxxx codes are illegal
      4'hE:    w_dec_adden    = 1'b1;
      4'hD:    w_dec_setinit  = 1'b1;
      4'hC:    w_dec_trig_set = 1'b1;
      4'hB:    w_dec_trig_clr = 1'b1;
      4'hA:    w_dec_settrig  = 1'b1;
      4'h9:    w_dec_softrld  = 1'b1;
      4'h8:    w_dec_serpll   = 1'b1;
      default: ;
    endcase
  end

  assign w_op_valid = w_dec_clrall | w_dec_adden | w_dec_setinit | w_dec_trig_set
                    | w_dec_trig_clr | w_dec_settrig | w_dec_softrld | w_dec_serpll;

  assign w_cmd_nxt  = w_exec_go && w_op_valid;
  assign w_ferr_nxt = w_abort || w_ck_err || w_timeout || (w_exec_go && !w_op_valid);

  always_comb begin
    w_trig_nxt = r_trig;
    if (w_cmd_nxt && (w_dec_clrall || w_dec_trig_set)) w_trig_nxt = 1'b1;
    else if (w_cmd_nxt && w_dec_trig_clr)              w_trig_nxt = 1'b0;
  end

  // Argument slot k lands MSB-first; the executed data is taken from this
  // next-value so a frame without checksum sees its own last byte.
  always_comb begin
    w_sh_data_nxt = r_sh_data;
    if (w_abort) begin
      w_sh_data_nxt = '0;
    end else if ((r_state == S_ARGS) && DataValid) begin
      for (int k = 0; k < ARG_BYTES; k++) begin
        if (r_arg_idx == AW'(k)) w_sh_data_nxt[(ARG_BYTES-1-k)*DW +: DW] = DataIn;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_sh_order <= '0;
      r_sh_data  <= '0;
      r_xor      <= '0;
      r_arg_idx  <= '0;
      r_tcnt     <= '0;
      r_order    <= '0;
      r_data     <= '0;
      r_cmd      <= 1'b0;
      r_clrall   <= 1'b0;
      r_adden    <= 1'b0;
      r_setinit  <= 1'b0;
      r_trig     <= 1'b1;
      r_settrig  <= 1'b0;
      r_softrld  <= 1'b0;
      r_serpll   <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_sh_data <= w_sh_data_nxt;

      if (w_abort) begin
        r_sh_order <= '0;
        r_xor      <= '0;
        r_arg_idx  <= '0;
      end else if ((r_state == S_ORDER) && DataValid) begin
        r_sh_order <= DataIn;
        r_xor      <= DataIn;
        r_arg_idx  <= '0;
      end else if ((r_state == S_ARGS) && DataValid) begin
        r_xor <= r_xor ^ DataIn;
        if (!w_last_arg) r_arg_idx <= r_arg_idx + AW'(1);
      end

      // Counts idle cycles inside a frame only.
      if (!w_in_frame || DataValid || w_timeout) r_tcnt <= '0;
      else if (TIMEOUT != 0)                     r_tcnt <= r_tcnt + TW'(1);

      if (w_cmd_nxt) begin
        r_order <= r_sh_order;
        r_data  <= w_sh_data_nxt;
      end

      r_cmd     <= w_cmd_nxt;
      r_clrall  <= w_cmd_nxt && w_dec_clrall;
      r_adden   <= w_cmd_nxt && w_dec_adden;
      r_setinit <= w_cmd_nxt && w_dec_setinit;
      r_settrig <= w_cmd_nxt && w_dec_settrig;
      r_softrld <= w_cmd_nxt && w_dec_softrld;
      r_serpll  <= w_cmd_nxt && w_dec_serpll;
      r_trig    <= w_trig_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  assign Order       = r_order;
  assign Data        = r_data;
  assign CmdStrobe   = r_cmd;
  assign ClrAll      = r_clrall;
  assign adden       = r_adden;
  assign SetInit     = r_setinit | !Locked;
  assign TrigEN      = r_trig;
  assign SetTrigTime = r_settrig;
  assign SoftReload  = r_softrld;
  assign SerPLL      = r_serpll;
  assign FrameErr    = r_ferr;
  assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_decoder
//
// Directed bench for cmd_frame_decoder (ARG_BYTES=2, CKSUM_EN=1, TIMEOUT=16).
// A table of frames with hand-computed expected outputs is applied in order,
// followed by hand-written sequences for abort, timeout, Locked and mid-frame
// reset. Pulse vector layout:
//   {CmdStrobe, FrameErr, ClrAll, adden, SetInit, SetTrigTime, SoftReload, SerPLL}
// -----------------------------------------------------------------------------
module tb_cmd_frame_decoder;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [7:0]  DataIn;
  logic        DataValid;
  logic        Locked;
  logic [7:0]  Order;
  logic [15:0] Data;
  logic CmdStrobe, ClrAll, adden, SetInit, TrigEN, SetTrigTime, SoftReload, SerPLL;
  logic FrameErr, Busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  cmd_frame_decoder #(
    .DW(8), .ARG_BYTES(2), .SYNC(8'hA5), .CKSUM_EN(1'b1), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .CLR(CLR), .DataIn(DataIn), .DataValid(DataValid), .Locked(Locked),
    .Order(Order), .Data(Data), .CmdStrobe(CmdStrobe), .ClrAll(ClrAll), .adden(adden),
    .SetInit(SetInit), .TrigEN(TrigEN), .SetTrigTime(SetTrigTime), .SoftReload(SoftReload),
    .SerPLL(SerPLL), .FrameErr(FrameErr), .Busy(Busy)
  );

  typedef struct {
    int          n;       // bytes used, taken from the MSB end of bytes
    logic [63:0] bytes;
    logic [7:0]  pulses;
    logic [7:0]  order;
    logic [15:0] data;
    logic        trig;
    logic        busy;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mkv(input int n, input logic [63:0] b, input logic [7:0] p,
                               input logic [7:0] o, input logic [15:0] d,
                               input logic t, input logic bz);
    vec_t v;
    v.n = n; v.bytes = b; v.pulses = p; v.order = o; v.data = d; v.trig = t; v.busy = bz;
    return v;
  endfunction

  function automatic logic [7:0] pulses();
    return {CmdStrobe, FrameErr, ClrAll, adden, SetInit, SetTrigTime, SoftReload, SerPLL};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    DataIn    = b;
    DataValid = 1'b1;
    tick();
    DataValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [63:0] b;
    b = v.bytes;
    for (int j = 0; j < v.n; j++) send_byte(b[63-8*j -: 8]);
    check({tag, " pulses"}, 32'(pulses()), 32'(v.pulses));
    check({tag, " order"},  32'(Order),    32'(v.order));
    check({tag, " data"},   32'(Data),     32'(v.data));
    check({tag, " trig"},   32'(TrigEN),   32'(v.trig));
    check({tag, " busy"},   32'(Busy),     32'(v.busy));
    tick();
    check({tag, " pulses_clr"}, 32'(pulses()), 32'h0);
    check({tag, " idle"},       32'(Busy),     32'h0);
  endtask

  initial begin
    //               n  bytes (first byte in MSBs)   pulses  order  data    trig busy
    vecs[0]  = mkv(6, 64'h33A5E10001E0_0000, 8'h90, 8'hE1, 16'h0001, 1'b1, 1'b1); // junk in IDLE ignored
    vecs[1]  = mkv(5, 64'hA5E31234C5_000000, 8'h90, 8'hE3, 16'h1234, 1'b1, 1'b1); // adden
    vecs[2]  = mkv(5, 64'hA5E31234C4_000000, 8'h40, 8'hE3, 16'h1234, 1'b1, 1'b0); // bad checksum
    vecs[3]  = mkv(5, 64'hA59FABCD00_000000, 8'h40, 8'hE3, 16'h1234, 1'b1, 1'b0); // bad checksum
    vecs[4]  = mkv(5, 64'hA5B00000B0_000000, 8'h80, 8'hB0, 16'h0000, 1'b0, 1'b1); // TrigEN clear
    vecs[5]  = mkv(5, 64'hA5C00000C0_000000, 8'h80, 8'hC0, 16'h0000, 1'b1, 1'b1); // TrigEN set
    vecs[6]  = mkv(5, 64'hA5B00000B0_000000, 8'h80, 8'hB0, 16'h0000, 1'b0, 1'b1); // TrigEN clear
    vecs[7]  = mkv(5, 64'hA5FF0000FF_000000, 8'hA0, 8'hFF, 16'h0000, 1'b1, 1'b1); // ClrAll sets TrigEN
    vecs[8]  = mkv(5, 64'hA5A20102A1_000000, 8'h84, 8'hA2, 16'h0102, 1'b1, 1'b1); // SetTrigTime
    vecs[9]  = mkv(5, 64'hA5831020B3_000000, 8'h81, 8'h83, 16'h1020, 1'b1, 1'b1); // SerPLL
    vecs[10] = mkv(5, 64'hA59FABCDF9_000000, 8'h82, 8'h9F, 16'hABCD, 1'b1, 1'b1); // SoftReload
    vecs[11] = mkv(5, 64'hA5F30000F3_000000, 8'h40, 8'h9F, 16'hABCD, 1'b1, 1'b1); // illegal 1111 code
    vecs[12] = mkv(5, 64'hA5D10000D1_000000, 8'h88, 8'hD1, 16'h0000, 1'b1, 1'b1); // SetInit
    vecs[13] = mkv(5, 64'hA570000070_000000, 8'h40, 8'hD1, 16'h0000, 1'b1, 1'b1); // illegal 0xxx code

    CLR = 1'b1; DataIn = 8'h00; DataValid = 1'b0; Locked = 1'b1;
    idle(2);
    check("rst order",  32'(Order),    32'h0);
    check("rst data",   32'(Data),     32'h0);
    check("rst pulses", 32'(pulses()), 32'h0);
    check("rst trig",   32'(TrigEN),   32'h1);
    check("rst busy",   32'(Busy),     32'h0);
    Locked = 1'b0; #1;
    check("rst setinit_unlocked", 32'(SetInit), 32'h1);
    Locked = 1'b1; #1;
    CLR = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // SYNC inside a frame aborts it and restarts at ORDER.
    send_byte(8'hA5); send_byte(8'hE3); send_byte(8'h12);
    send_byte(8'hA5);
    check("abort ferr",  32'(FrameErr), 32'h1);
    check("abort busy",  32'(Busy),     32'h1);
    check("abort order", 32'(Order),    32'hD1);
    send_byte(8'h90); send_byte(8'h00); send_byte(8'h01); send_byte(8'h91);
    check("abort_next pulses", 32'(pulses()), 32'h82);
    check("abort_next order",  32'(Order),    32'h90);
    check("abort_next data",   32'(Data),     32'h0001);
    idle(1);

    // Inter-byte timeout: FrameErr after the 16th idle cycle.
    send_byte(8'hA5); send_byte(8'hE3);
    idle(15);
    check("to pre ferr", 32'(FrameErr), 32'h0);
    check("to pre busy", 32'(Busy),     32'h1);
    idle(1);
    check("to ferr", 32'(FrameErr), 32'h1);
    check("to busy", 32'(Busy),     32'h0);
    idle(1);
    check("to ferr_clr", 32'(FrameErr), 32'h0);

    // A byte in the expiry cycle beats the timeout.
    send_byte(8'hA5); send_byte(8'hE3);
    idle(15);
    send_byte(8'h12);
    check("exp ferr", 32'(FrameErr), 32'h0);
    check("exp busy", 32'(Busy),     32'h1);
    send_byte(8'h34); send_byte(8'hC5);
    check("exp pulses", 32'(pulses()), 32'h90);
    check("exp data",   32'(Data),     32'h1234);
    idle(1);

    // Loss of lock drives SetInit with no command.
    Locked = 1'b0;
    tick();
    check("unlock setinit", 32'(SetInit),   32'h1);
    check("unlock cmd",     32'(CmdStrobe), 32'h0);
    Locked = 1'b1; #1;
    check("lock setinit", 32'(SetInit), 32'h0);

    // Reset mid-frame with TrigEN low.
    run_vec("pre_clr", vecs[6]);
    send_byte(8'hA5); send_byte(8'hD1);
    CLR = 1'b1;
    tick();
    check("clr order",  32'(Order),    32'h0);
    check("clr data",   32'(Data),     32'h0);
    check("clr pulses", 32'(pulses()), 32'h0);
    check("clr trig",   32'(TrigEN),   32'h1);
    check("clr busy",   32'(Busy),     32'h0);
    CLR = 1'b0;
    tick();
    run_vec("post_clr_d1", vecs[12]);
    run_vec("post_clr_70", vecs[13]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
